// File: rtl/lathe_input_conditioner.sv
// lathe_input_conditioner
// -----------------------
// Front-end conditioning for the lathe PLC core. Each raw operator input
// (START, STOP, AUTO, MAN, SEL0) passes through a 2-flop synchroniser and a
// counting debouncer. The debounced levels drive:
//   - rising-edge detectors for START and STOP,
//   - an operating-mode FSM (NONE / AUTO / MAN / FAULT) built on AUTO and MAN,
//   - STOP-dominant start/stop command pulses for the core's run latch,
//   - a saturating counter of rejected bounces summed over all channels.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   start_raw..sel0_raw raw pushbutton / selector inputs (asynchronous)
//   start_pulse         one-cycle start command (suppressed by any stop cause)
//   stop_pulse          one-cycle stop command (stop rise or leaving AUTO/MAN)
//   stop_lvl, sel0_db   debounced STOP and SEL0 levels
//   auto_mode, man_mode, mode_fault   registered decode of the mode FSM
//   reject_cnt          saturating count of rejected bounces, all channels
//
// Handshake: none. Every output is a registered level or a one-cycle pulse
// valid from the clock edge that produces it; the core samples each cycle.
module lathe_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REJ_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_raw,
  input  logic             stop_raw,
  input  logic             auto_raw,
  input  logic             man_raw,
  input  logic             sel0_raw,
  output logic             start_pulse,
  output logic             stop_pulse,
  output logic             stop_lvl,
  output logic             sel0_db,
  output logic             auto_mode,
  output logic             man_mode,
  output logic             mode_fault,
  output logic [REJ_W-1:0] reject_cnt
);

  localparam int NCH      = 5;
  localparam int CH_START = 0;
  localparam int CH_STOP  = 1;
  localparam int CH_AUTO  = 2;
  localparam int CH_MAN   = 3;
  localparam int CH_SEL0  = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REJ_W-1:0] REJ_MAX  = {REJ_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_AUTO  = 2'd1,
    MODE_MAN   = 2'd2,
    MODE_FAULT = 2'd3
  } mode_e;

  logic [NCH-1:0] raw;
  assign raw = {sel0_raw, man_raw, auto_raw, stop_raw, start_raw};

  // Per-channel state
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] db_q, db_d;
  logic [NCH-1:0] db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0] rej_hit;

  // Shared state
  logic [REJ_W-1:0] reject_q, reject_d;
  mode_e            mode_q, mode_d;
  logic             start_pulse_q, start_pulse_d;
  logic             stop_pulse_q, stop_pulse_d;
  logic             auto_mode_q, auto_mode_d;
  logic             man_mode_q, man_mode_d;
  logic             mode_fault_q, mode_fault_d;

  logic [NCH-1:0] rise;
  logic [2:0]     rej_sum;
  logic [REJ_W:0] rej_ext;
  logic           a_lvl, m_lvl;
  logic           in_run;
  logic           leave_run;

  // Synchroniser and debouncer. A channel whose synchronised level falls back
  // to the debounced level while a count is in progress is a rejected bounce.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    rej_hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i]   = '0;
        rej_hit[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Rejects on several channels in the same cycle all count; the extra top
  // bit of rej_ext catches overflow so the counter sticks at all-ones.
  always_comb begin
    rej_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      rej_sum = rej_sum + {2'b00, rej_hit[i]};
    end
    rej_ext  = {1'b0, reject_q} + (REJ_W+1)'(rej_sum);
    reject_d = rej_ext[REJ_W] ? REJ_MAX : rej_ext[REJ_W-1:0];
  end

  assign rise  = db_q & ~db_prev_q;
  assign a_lvl = db_q[CH_AUTO];
  assign m_lvl = db_q[CH_MAN];

  // Mode FSM next state. AUTO and MAN never swap directly: dropping the
  // active selector always passes through NONE first.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_NONE: begin
        if (a_lvl && m_lvl)      mode_d = MODE_FAULT;
        else if (a_lvl)          mode_d = MODE_AUTO;
        else if (m_lvl)          mode_d = MODE_MAN;
      end
      MODE_AUTO: begin
        if (a_lvl && m_lvl)      mode_d = MODE_FAULT;
        else if (!a_lvl)         mode_d = MODE_NONE;
      end
      MODE_MAN: begin
        if (a_lvl && m_lvl)      mode_d = MODE_FAULT;
        else if (!m_lvl)         mode_d = MODE_NONE;
      end
      MODE_FAULT: begin
        if (!a_lvl && !m_lvl)    mode_d = MODE_NONE;
      end
      default:                   mode_d = MODE_NONE;
    endcase
  end

  // Command pulses. Any stop cause in the same cycle kills a start rise, and
  // the killed start is dropped rather than held for later.
  always_comb begin
    in_run        = (mode_q == MODE_AUTO) || (mode_q == MODE_MAN);
    leave_run     = in_run && (mode_d != mode_q);
    stop_pulse_d  = rise[CH_STOP] | leave_run;
    start_pulse_d = rise[CH_START] & ~db_q[CH_STOP] & in_run & ~stop_pulse_d;
    auto_mode_d   = (mode_q == MODE_AUTO);
    man_mode_d    = (mode_q == MODE_MAN);
    mode_fault_d  = (mode_q == MODE_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_q          <= '0;
      db_prev_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      reject_q      <= '0;
      mode_q        <= MODE_NONE;
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
      auto_mode_q   <= 1'b0;
      man_mode_q    <= 1'b0;
      mode_fault_q  <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      db_prev_q     <= db_prev_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      reject_q      <= reject_d;
      mode_q        <= mode_d;
      start_pulse_q <= start_pulse_d;
      stop_pulse_q  <= stop_pulse_d;
      auto_mode_q   <= auto_mode_d;
      man_mode_q    <= man_mode_d;
      mode_fault_q  <= mode_fault_d;
    end
  end

  assign start_pulse = start_pulse_q;
  assign stop_pulse  = stop_pulse_q;
  assign stop_lvl    = db_q[CH_STOP];
  assign sel0_db     = db_q[CH_SEL0];
  assign auto_mode   = auto_mode_q;
  assign man_mode    = man_mode_q;
  assign mode_fault  = mode_fault_q;
  assign reject_cnt  = reject_q;

endmodule
